// File: rtl/toy_phy_reg_prealloc_buffer.sv
// toy_phy_reg_prealloc_buffer
// In-order buffer of pre-allocated physical register IDs. It sits between the
// regfile pre-allocate port and the rename lanes.
// - Push: compacts accepted allocate lanes into the tail of a circular array.
// - Pop: hands IDs to the requesting rename lanes at zero latency, in order.
// - Cancel: flushes the buffer and returns every held ID as a one-cycle
//   release mask.

module toy_phy_reg_prealloc_buffer #(
  parameter int DEPTH    = 8,
  parameter int LANE_NUM = 4,
  parameter int ID_WIDTH = 6,
  parameter int REG_NUM  = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [LANE_NUM-1:0]          v_alloc_vld,
  input  logic [ID_WIDTH*LANE_NUM-1:0] v_alloc_id,
  output logic [LANE_NUM-1:0]          v_alloc_rdy,
  input  logic [LANE_NUM-1:0]          v_req,
  input  logic                         req_vld,
  output logic                         grp_rdy,
  output logic [LANE_NUM-1:0]          v_out_vld,
  output logic [ID_WIDTH*LANE_NUM-1:0] v_out_id,
  input  logic                         cancel_en,
  input  logic                         cancel_edge_en,
  output logic [REG_NUM-1:0]           v_release,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Number of set bits in a lane mask; the result always fits in CNT_W
  // because LANE_NUM never exceeds DEPTH.
  function automatic logic [CNT_W-1:0] popcnt(input logic [LANE_NUM-1:0] v);
    logic [CNT_W-1:0] c;
    c = {CNT_W{1'b0}};
    for (int i = 0; i < LANE_NUM; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  logic [ID_WIDTH-1:0] entries_r [DEPTH];
  logic [PTR_W-1:0]    head_r;
  logic [PTR_W-1:0]    tail_r;
  logic [CNT_W-1:0]    count_r;
  logic [REG_NUM-1:0]  release_r;

  logic                cancel_s;
  logic                alloc_rdy_s;
  logic [LANE_NUM-1:0] accept_s;
  logic [CNT_W-1:0]    push_cnt_s;
  logic [CNT_W-1:0]    need_s;
  logic                grp_rdy_s;
  logic                pop_s;
  logic [CNT_W-1:0]    pop_cnt_s;
  logic [CNT_W-1:0]    count_next_s;
  logic                wr_en_s  [DEPTH];
  logic [ID_WIDTH-1:0] wr_id_s  [DEPTH];
  logic [REG_NUM-1:0]  flush_mask_s;

  // Push/pop handshake. Push readiness depends only on the registered count
  // and the cancel inputs, so it has no path from v_alloc_vld.
  always_comb begin
    cancel_s     = cancel_en | cancel_edge_en;
    alloc_rdy_s  = ((CNT_W'(DEPTH) - count_r) >= CNT_W'(LANE_NUM)) & ~cancel_s;
    accept_s     = v_alloc_vld & {LANE_NUM{alloc_rdy_s}};
    push_cnt_s   = popcnt(accept_s);
    need_s       = popcnt(v_req);
    grp_rdy_s    = (count_r >= need_s) & ~cancel_s;
    pop_s        = req_vld & grp_rdy_s;
    pop_cnt_s    = pop_s ? need_s : {CNT_W{1'b0}};
    count_next_s = count_r + push_cnt_s - pop_cnt_s;
  end

  // Compact the accepted lanes, in ascending lane order, onto consecutive
  // slots starting at tail.
  always_comb begin
    logic [CNT_W-1:0] off;
    logic [PTR_W-1:0] slot;
    off  = {CNT_W{1'b0}};
    slot = {PTR_W{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      wr_en_s[k] = 1'b0;
      wr_id_s[k] = {ID_WIDTH{1'b0}};
    end
    for (int i = 0; i < LANE_NUM; i++) begin
      slot = tail_r + PTR_W'(off);
      if (accept_s[i]) begin
        wr_en_s[slot] = 1'b1;
        wr_id_s[slot] = v_alloc_id[i*ID_WIDTH +: ID_WIDTH];
        off           = off + CNT_W'(1);
      end else begin
        off = off;
      end
    end
  end

  // Zero-latency read. Each requesting lane takes the entry at head plus the
  // number of requesting lanes below it. Lanes without a request see
  // whatever that same indexing selects.
  always_comb begin
    logic [CNT_W-1:0] pre;
    pre      = {CNT_W{1'b0}};
    v_out_id = {ID_WIDTH*LANE_NUM{1'b0}};
    for (int i = 0; i < LANE_NUM; i++) begin
      v_out_id[i*ID_WIDTH +: ID_WIDTH] = entries_r[head_r + PTR_W'(pre)];
      pre = pre + CNT_W'(v_req[i]);
    end
  end

  // Release mask: one bit for every ID held in head .. head+count-1.
  always_comb begin
    logic             hit;
    logic [PTR_W-1:0] idx;
    flush_mask_s = {REG_NUM{1'b0}};
    hit          = 1'b0;
    idx          = {PTR_W{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      hit = (CNT_W'(k) < count_r);
      idx = head_r + PTR_W'(k);
      flush_mask_s[entries_r[idx]] = flush_mask_s[entries_r[idx]] | hit;
    end
  end

  // Pointer, count and release state. A cancel edge empties the buffer and
  // captures the release mask. No push or pop happens in that cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_r    <= {PTR_W{1'b0}};
      tail_r    <= {PTR_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      release_r <= {REG_NUM{1'b0}};
    end else if (cancel_edge_en) begin
      head_r    <= {PTR_W{1'b0}};
      tail_r    <= {PTR_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      release_r <= flush_mask_s;
    end else begin
      head_r    <= head_r + PTR_W'(pop_cnt_s);
      tail_r    <= tail_r + PTR_W'(push_cnt_s);
      count_r   <= count_next_s;
      release_r <= {REG_NUM{1'b0}};
    end
  end

  // Entry storage. Accepted pushes only occur outside a cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        entries_r[k] <= {ID_WIDTH{1'b0}};
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (wr_en_s[k]) begin
          entries_r[k] <= wr_id_s[k];
        end else begin
          entries_r[k] <= entries_r[k];
        end
      end
    end
  end

  // Output drive.
  always_comb begin
    v_alloc_rdy = {LANE_NUM{alloc_rdy_s}};
    grp_rdy     = grp_rdy_s;
    v_out_vld   = v_req & {LANE_NUM{pop_s}};
    v_release   = release_r;
    count       = count_r;
  end

  toy_phy_reg_prealloc_buffer_chk #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .count (count_r)
  );

endmodule

// Occupancy checker. The count can never exceed the array size.
module toy_phy_reg_prealloc_buffer_chk #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input logic             clk,
  input logic             rst_n,
  input logic [CNT_W-1:0] count
);

  a_count_le_depth: assert property (
    @(posedge clk) disable iff (!rst_n) count <= CNT_W'(DEPTH)
  );

endmodule

// File: tb/tb_toy_phy_reg_prealloc_buffer.sv
// Directed table-driven bench for toy_phy_reg_prealloc_buffer
// (DEPTH=8, 4 lanes, 6-bit IDs, 64-bit release mask).
module tb_toy_phy_reg_prealloc_buffer;

  localparam int DEPTH = 8;
  localparam int LN    = 4;
  localparam int IW    = 6;
  localparam int RN    = 64;

  logic              clk;
  logic              rst_n;
  logic [LN-1:0]     v_alloc_vld;
  logic [IW*LN-1:0]  v_alloc_id;
  logic [LN-1:0]     v_alloc_rdy;
  logic [LN-1:0]     v_req;
  logic              req_vld;
  logic              grp_rdy;
  logic [LN-1:0]     v_out_vld;
  logic [IW*LN-1:0]  v_out_id;
  logic              cancel_en;
  logic              cancel_edge_en;
  logic [RN-1:0]     v_release;
  logic [3:0]        count;

  int tests_run;
  int tests_failed;

  toy_phy_reg_prealloc_buffer #(
    .DEPTH(DEPTH), .LANE_NUM(LN), .ID_WIDTH(IW), .REG_NUM(RN)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .v_alloc_vld(v_alloc_vld), .v_alloc_id(v_alloc_id), .v_alloc_rdy(v_alloc_rdy),
    .v_req(v_req), .req_vld(req_vld), .grp_rdy(grp_rdy),
    .v_out_vld(v_out_vld), .v_out_id(v_out_id),
    .cancel_en(cancel_en), .cancel_edge_en(cancel_edge_en),
    .v_release(v_release), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [LN-1:0]    vld;
    logic [IW*LN-1:0] ids;
    logic [LN-1:0]    req;
    logic             rv;
    logic [3:0]       e_cnt;
    logic [LN-1:0]    e_rdy;
    logic             e_grp;
    logic [LN-1:0]    e_ov;
    logic [IW*LN-1:0] e_ids;
  } vec_t;

  vec_t tbl [15];

  function automatic logic [IW*LN-1:0] ids4(input int l0, input int l1, input int l2, input int l3);
    return {IW'(l3), IW'(l2), IW'(l1), IW'(l0)};
  endfunction

  function automatic vec_t mk(input logic [LN-1:0] vld, input logic [IW*LN-1:0] ids,
                              input logic [LN-1:0] req, input logic rv,
                              input logic [3:0] e_cnt, input logic [LN-1:0] e_rdy,
                              input logic e_grp, input logic [LN-1:0] e_ov,
                              input logic [IW*LN-1:0] e_ids);
    vec_t v;
    v.vld = vld; v.ids = ids; v.req = req; v.rv = rv;
    v.e_cnt = e_cnt; v.e_rdy = e_rdy; v.e_grp = e_grp; v.e_ov = e_ov; v.e_ids = e_ids;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [LN-1:0] vld, input logic [IW*LN-1:0] ids,
                       input logic [LN-1:0] req, input logic rv,
                       input logic edge_en, input logic lvl_en);
    v_alloc_vld    = vld;
    v_alloc_id     = ids;
    v_req          = req;
    req_vld        = rv;
    cancel_edge_en = edge_en;
    cancel_en      = lvl_en;
  endtask

  logic [RN-1:0] exp_rel;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    drive('0, '0, '0, 1'b0, 1'b0, 1'b0);

    //        vld    ids                 req    rv    cnt  rdy    grp   ov     exp ids
    tbl[0]  = mk(4'hF, ids4(10,11,12,13), 4'h0, 1'b0, 4'd0, 4'hF, 1'b1, 4'h0, ids4(0,0,0,0));
    tbl[1]  = mk(4'h0, ids4(0,0,0,0),     4'h5, 1'b1, 4'd4, 4'hF, 1'b1, 4'h5, ids4(10,0,11,0));
    tbl[2]  = mk(4'h7, ids4(14,15,16,0),  4'h0, 1'b0, 4'd2, 4'hF, 1'b1, 4'h0, ids4(0,0,0,0));
    tbl[3]  = mk(4'hF, ids4(40,41,42,43), 4'h3, 1'b1, 4'd5, 4'h0, 1'b1, 4'h3, ids4(12,13,0,0));
    tbl[4]  = mk(4'h0, ids4(0,0,0,0),     4'hC, 1'b1, 4'd3, 4'hF, 1'b1, 4'hC, ids4(0,0,14,15));
    tbl[5]  = mk(4'h0, ids4(0,0,0,0),     4'h3, 1'b1, 4'd1, 4'hF, 1'b0, 4'h0, ids4(0,0,0,0));
    tbl[6]  = mk(4'h0, ids4(0,0,0,0),     4'h0, 1'b1, 4'd1, 4'hF, 1'b1, 4'h0, ids4(0,0,0,0));
    tbl[7]  = mk(4'hA, ids4(50,20,51,21), 4'h1, 1'b1, 4'd1, 4'hF, 1'b1, 4'h1, ids4(16,0,0,0));
    tbl[8]  = mk(4'h0, ids4(0,0,0,0),     4'h3, 1'b1, 4'd2, 4'hF, 1'b1, 4'h3, ids4(20,21,0,0));
    tbl[9]  = mk(4'hF, ids4(30,31,32,33), 4'h0, 1'b0, 4'd0, 4'hF, 1'b1, 4'h0, ids4(0,0,0,0));
    tbl[10] = mk(4'h0, ids4(0,0,0,0),     4'hF, 1'b1, 4'd4, 4'hF, 1'b1, 4'hF, ids4(30,31,32,33));
    tbl[11] = mk(4'hF, ids4(34,35,36,37), 4'h0, 1'b0, 4'd0, 4'hF, 1'b1, 4'h0, ids4(0,0,0,0));
    tbl[12] = mk(4'h0, ids4(0,0,0,0),     4'h1, 1'b1, 4'd4, 4'hF, 1'b1, 4'h1, ids4(34,0,0,0));
    tbl[13] = mk(4'h0, ids4(0,0,0,0),     4'h7, 1'b1, 4'd3, 4'hF, 1'b1, 4'h7, ids4(35,36,37,0));
    tbl[14] = mk(4'h0, ids4(0,0,0,0),     4'h1, 1'b1, 4'd0, 4'hF, 1'b0, 4'h0, ids4(0,0,0,0));

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_count",   64'(count), 64'd0);
    check("rst_rdy",     64'(v_alloc_rdy), 64'hF);
    check("rst_grp_req0", 64'(grp_rdy), 64'd1);
    check("rst_out_vld", 64'(v_out_vld), 64'd0);
    check("rst_out_id",  64'(v_out_id), 64'd0);
    check("rst_release", v_release, 64'd0);
    v_req = 4'h3;
    #1;
    check("rst_grp_req3", 64'(grp_rdy), 64'd0);
    v_req = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;

    // Table: push, pop, full, underflow, mixed push/pop, wrap
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(tbl[i].vld, tbl[i].ids, tbl[i].req, tbl[i].rv, 1'b0, 1'b0);
      #1;
      check($sformatf("v%0d_count", i), 64'(count), 64'(tbl[i].e_cnt));
      check($sformatf("v%0d_rdy", i), 64'(v_alloc_rdy), 64'(tbl[i].e_rdy));
      check($sformatf("v%0d_grp", i), 64'(grp_rdy), 64'(tbl[i].e_grp));
      check($sformatf("v%0d_ovld", i), 64'(v_out_vld), 64'(tbl[i].e_ov));
      for (int l = 0; l < LN; l++) begin
        if (tbl[i].e_ov[l]) begin
          check($sformatf("v%0d_id%0d", i, l), 64'(v_out_id[l*IW +: IW]),
                64'(tbl[i].e_ids[l*IW +: IW]));
        end
      end
    end

    // Flush: hold IDs 5, 9, 33, then cancel
    @(negedge clk);
    drive(4'h7, ids4(5,9,33,0), 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(4'hF, ids4(1,2,3,4), 4'h1, 1'b1, 1'b1, 1'b1);
    #1;
    check("fl_edge_count", 64'(count), 64'd3);
    check("fl_edge_rdy", 64'(v_alloc_rdy), 64'd0);
    check("fl_edge_grp", 64'(grp_rdy), 64'd0);
    check("fl_edge_ovld", 64'(v_out_vld), 64'd0);
    check("fl_edge_rel", v_release, 64'd0);
    @(negedge clk);
    drive(4'hF, ids4(1,2,3,4), 4'h1, 1'b1, 1'b0, 1'b1);
    #1;
    exp_rel = '0;
    exp_rel[5] = 1'b1; exp_rel[9] = 1'b1; exp_rel[33] = 1'b1;
    check("fl_rel_mask", v_release, exp_rel);
    check("fl_count0", 64'(count), 64'd0);
    check("fl_lvl_rdy", 64'(v_alloc_rdy), 64'd0);
    check("fl_lvl_grp", 64'(grp_rdy), 64'd0);
    check("fl_lvl_ovld", 64'(v_out_vld), 64'd0);
    @(negedge clk);
    drive(4'h0, '0, 4'h0, 1'b0, 1'b0, 1'b0);
    #1;
    check("fl_rel_clear", v_release, 64'd0);
    check("fl_idle_count", 64'(count), 64'd0);
    check("fl_idle_rdy", 64'(v_alloc_rdy), 64'hF);
    check("fl_idle_grp", 64'(grp_rdy), 64'd1);

    // Reset mid-operation: contents dropped, no release pulse
    @(negedge clk);
    drive(4'hF, ids4(1,2,3,4), 4'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(4'h0, '0, 4'hF, 1'b0, 1'b0, 1'b0);
    #1;
    check("mr_count_before", 64'(count), 64'd4);
    check("mr_id_before", 64'(v_out_id), 64'(ids4(1,2,3,4)));
    rst_n = 1'b0;
    #1;
    check("mr_count", 64'(count), 64'd0);
    check("mr_out_id", 64'(v_out_id), 64'd0);
    check("mr_grp", 64'(grp_rdy), 64'd0);
    check("mr_rel", v_release, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("mr_rel_after", v_release, 64'd0);
    check("mr_count_after", 64'(count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
